// File: rtl/proc_pkg.sv
// Shared opcode/state encodings for the multicycle accumulator processor.
// The optional carry flag and JC opcode are built only when PROC_CARRY_EN is defined.
package proc_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_JMP   = 4'd5,
    OP_JZ    = 4'd6,
    OP_HALT  = 4'd7,
    OP_JC    = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPRD,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

endpackage

// File: rtl/multicycle_acc_processor_if.sv
// Memory-port bundle between the processor (master) and the memory model / top level (slave).
interface multicycle_acc_processor_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  // Memory protocol: one access per cycle, no valid/ready. readwriteN=1 writes data_out to
  // address on the next rising edge; readwriteN=0 reads, and data_in returns mem[address]
  // one cycle after the address was presented. run gates only new instruction fetches.
  logic              run;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              readwriteN;
  logic [ADDR_W-1:0] address;
  logic              halted;

  modport master (input run, data_in, output data_out, readwriteN, address, halted);
  modport slave  (output run, data_in, input data_out, readwriteN, address, halted);
endinterface

// File: rtl/proc_alu.sv
// Combinational accumulator ALU: LOAD pass-through, ADD, SUB (a-b) and MUL (low half kept).
// carry reports ADD carry-out, SUB borrow or a nonzero MUL high half; LOAD returns carry=0.
module proc_alu
  import proc_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  opcode_t         op,
  output logic [OP_W-1:0] result,
  output logic            carry
);

  logic [OP_W:0]     sum;
  logic [2*OP_W-1:0] product;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign product = (2*OP_W)'(a) * (2*OP_W)'(b);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_LOAD: result = b;
      OP_ADD:  {carry, result} = sum;
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_MUL: begin
        result = product[OP_W-1:0];
        carry  = |product[2*OP_W-1:OP_W];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_acc_processor.sv
// Multicycle accumulator processor: FSM, PC, IR, ACC (and CARRY when PROC_CARRY_EN is defined)
// sharing one synchronous memory port; all memory-side outputs are registered.
module multicycle_acc_processor
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_acc_processor_if.master bus,
  output state_t                     state_dbg,
  output logic [ADDR_W-1:0]          pc_dbg,
  output logic [OP_W-1:0]            acc_dbg,
  output logic                       carry_dbg
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [OP_W-1:0]   acc;
  logic [ADDR_W-1:0] address_q;
  logic              rw_q;
  logic [DATA_W-1:0] data_out_q;
  logic              halted_q;

  opcode_t           fetched_op;
  opcode_t           ir_op;
  logic [ADDR_W-1:0] fetched_opd;
  logic [ADDR_W-1:0] pc_next;
  logic [OP_W-1:0]   alu_result;
  logic              alu_carry;

  assign fetched_op  = opcode_t'(bus.data_in[DATA_W-1 -: OPC_W]);
  assign fetched_opd = bus.data_in[ADDR_W-1:0];
  assign ir_op       = opcode_t'(ir[DATA_W-1 -: OPC_W]);
  assign pc_next     = pc + ADDR_W'(1);

  proc_alu #(.OP_W(OP_W)) u_alu (
    .a      (acc),
    .b      (bus.data_in[OP_W-1:0]),
    .op     (ir_op),
    .result (alu_result),
    .carry  (alu_carry)
  );

`ifdef PROC_CARRY_EN
  logic carry;
  assign carry_dbg = carry;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
  assign carry_dbg        = 1'b0;
`endif

  // Outputs are loaded for the state being entered, so each state sees its own address/strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      acc        <= '0;
      address_q  <= '0;
      rw_q       <= 1'b0;
      data_out_q <= '0;
      halted_q   <= 1'b0;
`ifdef PROC_CARRY_EN
      carry      <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.run) state <= S_DECODE;
        end
        S_DECODE: begin
          ir        <= bus.data_in;
          pc        <= pc_next;
          address_q <= pc_next;
          case (fetched_op)
            OP_LOAD, OP_ADD, OP_SUB, OP_MUL: begin
              state     <= S_OPRD;
              address_q <= fetched_opd;
            end
            OP_STORE: begin
              state      <= S_WRITE;
              address_q  <= fetched_opd;
              rw_q       <= 1'b1;
              data_out_q <= DATA_W'(acc);
            end
            OP_JMP: begin
              state     <= S_FETCH;
              pc        <= fetched_opd;
              address_q <= fetched_opd;
            end
            OP_JZ: begin
              state <= S_FETCH;
              if (acc == '0) begin
                pc        <= fetched_opd;
                address_q <= fetched_opd;
              end
            end
`ifdef PROC_CARRY_EN
            OP_JC: begin
              state <= S_FETCH;
              if (carry) begin
                pc        <= fetched_opd;
                address_q <= fetched_opd;
              end
            end
`endif
            default: begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end
          endcase
        end
        S_OPRD: state <= S_EXEC;
        S_EXEC: begin
          acc       <= alu_result;
`ifdef PROC_CARRY_EN
          carry     <= alu_carry;
`endif
          state     <= S_FETCH;
          address_q <= pc;
        end
        S_WRITE: begin
          rw_q       <= 1'b0;
          data_out_q <= '0;
          state      <= S_FETCH;
          address_q  <= pc;
        end
        default: begin
          state    <= S_HALT;
          halted_q <= 1'b1;
          rw_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address    = address_q;
  assign bus.readwriteN = rw_q;
  assign bus.data_out   = data_out_q;
  assign bus.halted     = halted_q;

  assign state_dbg = state;
  assign pc_dbg    = pc;
  assign acc_dbg   = acc;

endmodule

// File: tb/tb_multicycle_acc_processor.sv
// Bench for multicycle_acc_processor: table vectors, directed multi-cycle sequences and random
// programs checked against an instruction-level model. Builds with or without PROC_CARRY_EN.
module tb_multicycle_acc_processor;
  import proc_pkg::*;

`ifdef PROC_CARRY_EN
  localparam bit CARRY_BUILD = 1'b1;
`else
  localparam bit CARRY_BUILD = 1'b0;
`endif
  localparam int W = 21;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_req = 1'b0;
  logic sb_en = 1'b0;
  logic [15:0] rdata;
  logic [15:0] mem [32];
  logic [15:0] img [32];
  logic [15:0] model_mem [32];
  logic [W-1:0] exp_q [$];

  state_t      state_dbg;
  logic [4:0]  pc_dbg;
  logic [7:0]  acc_dbg;
  logic        carry_dbg;

  multicycle_acc_processor_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  multicycle_acc_processor #(.DATA_W(16), .ADDR_W(5), .OP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg),
    .pc_dbg    (pc_dbg),
    .acc_dbg   (acc_dbg),
    .carry_dbg (carry_dbg)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (bus.readwriteN) mem[bus.address] <= bus.data_out;
    rdata <= mem[bus.address];
  end
  assign bus.data_in = rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next modelled STORE
  always @(negedge clk) begin
    if (sb_en && rst_n && bus.readwriteN) begin
      if (exp_q.size() == 0) check("rand_store_unexpected", {11'd0, bus.address, bus.data_out}, 32'hFFFF_FFFF);
      else check("rand_store", {11'd0, bus.address, bus.data_out}, {11'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  function automatic logic [15:0] ins(input logic [3:0] op, input int opd);
    return {op, 7'd0, 5'(opd)};
  endfunction

  task automatic clear_img();
    for (int a = 0; a < 32; a++) img[a] = 16'h7000;
  endtask

  task automatic reset_and_load(input logic run_v);
    @(negedge clk);
    rst_n = 1'b0;
    bus.run = run_v;
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!bus.halted && cycles < budget) begin
      step(1);
      cycles++;
    end
    if (!bus.halted) check("halt_timeout", 32'd0, 32'd1);
  endtask

  // instruction-level reference model; queues expected STOREs and returns totals
  task automatic model_run(output int cyc, output logic [7:0] acc_o, output logic [4:0] pc_o);
    logic [15:0] m [32];
    logic [3:0] opc;
    int pc, acc, cy, opd, b, steps;
    bit done;
    m = img; pc = 0; acc = 0; cy = 0; cyc = 0; done = 1'b0; steps = 0;
    while (!done && steps < 64) begin
      opc = m[pc][15:12];
      opd = int'(m[pc][4:0]);
      b   = int'(m[opd][7:0]);
      pc  = (pc + 1) % 32;
      steps++;
      case (opc)
        4'd0: begin acc = b; cy = 0; cyc += 4; end
        4'd1: begin m[opd] = 16'(acc); exp_q.push_back({5'(opd), 16'(acc)}); cyc += 3; end
        4'd2: begin acc = acc + b; cy = int'(acc > 255); acc = acc % 256; cyc += 4; end
        4'd3: begin cy = int'(acc < b); acc = (acc - b + 256) % 256; cyc += 4; end
        4'd4: begin acc = acc * b; cy = int'(acc > 255); acc = acc % 256; cyc += 4; end
        4'd5: begin pc = opd; cyc += 2; end
        4'd6: begin if (acc == 0) pc = opd; cyc += 2; end
        4'd8: begin
          if (CARRY_BUILD) begin if (cy != 0) pc = opd; end
          else done = 1'b1;
          cyc += 2;
        end
        default: begin done = 1'b1; cyc += 2; end
      endcase
    end
    model_mem = m;
    acc_o = 8'(acc);
    pc_o = 5'(pc);
  endtask

  task automatic prog_basic();
    clear_img();
    img[0] = ins(4'd0, 10); img[1] = ins(4'd2, 11);
    img[2] = ins(4'd1, 12); img[3] = ins(4'd7, 0);
    img[10] = 16'd5; img[11] = 16'd7; img[12] = 16'h5555;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  exp_acc;
    logic        exp_c;
  } vec_t;

  vec_t vecs [9];
  int cyc, exp_cyc, wait_n, bad;
  logic [7:0] exp_acc;
  logic [4:0] exp_pc;
  int opc_tbl [12] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 6, 8, 8};

  initial begin
    vecs[0] = '{4'd2, 16'h0005, 16'h0007, 8'h0C, 1'b0};
    vecs[1] = '{4'd2, 16'h00FF, 16'h0001, 8'h00, 1'b1};
    vecs[2] = '{4'd3, 16'h0003, 16'h0005, 8'hFE, 1'b1};
    vecs[3] = '{4'd3, 16'h0009, 16'h0004, 8'h05, 1'b0};
    vecs[4] = '{4'd4, 16'h0020, 16'h0010, 8'h00, 1'b1};
    vecs[5] = '{4'd4, 16'h0007, 16'h0006, 8'h2A, 1'b0};
    vecs[6] = '{4'd4, 16'h000F, 16'h0011, 8'hFF, 1'b0};
    vecs[7] = '{4'd0, 16'h0011, 16'hAB33, 8'h33, 1'b0};
    vecs[8] = '{4'd2, 16'hFF03, 16'h1204, 8'h07, 1'b0};

    bus.run = 1'b0;
    #1;
    check("reset_outputs", {bus.readwriteN, bus.halted, 11'd0, bus.address, bus.data_out}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_FETCH));

    // basic program: result 12 stored, halted exactly at cycle 13
    prog_basic();
    reset_and_load(1'b1);
    run_to_halt(100, cyc);
    check("basic_cycles", cyc, 13);
    check("basic_mem12", mem[12], 16'd12);

    // table vectors: LOAD a; <op> b; STORE; HALT
    for (int v = 0; v < $size(vecs); v++) begin
      clear_img();
      img[0] = ins(4'd0, 20); img[1] = ins(vecs[v].op, 21);
      img[2] = ins(4'd1, 22); img[3] = ins(4'd7, 0);
      img[20] = vecs[v].a; img[21] = vecs[v].b; img[22] = 16'hDEAD;
      reset_and_load(1'b1);
      run_to_halt(100, cyc);
      check($sformatf("vec%0d_store", v), mem[22], {8'h00, vecs[v].exp_acc});
      check($sformatf("vec%0d_cycles", v), cyc, 13);
`ifdef PROC_CARRY_EN
      check($sformatf("vec%0d_carry", v), carry_dbg, vecs[v].exp_c);
`else
      check($sformatf("vec%0d_carry", v), carry_dbg, 1'b0);
`endif
    end

    // SUB borrow then JC 20 (opcode 8 halts when carry support is absent)
    clear_img();
    img[0] = ins(4'd0, 10); img[1] = ins(4'd3, 11); img[2] = ins(4'd8, 20);
    img[20] = ins(4'd1, 12);
    img[10] = 16'd3; img[11] = 16'd5; img[12] = 16'h5555;
    reset_and_load(1'b1);
    run_to_halt(100, cyc);
`ifdef PROC_CARRY_EN
    check("jc_mem12", mem[12], 16'h00FE);
    check("jc_cycles", cyc, 15);
    check("jc_pc", pc_dbg, 5'd22);
`else
    check("op8_mem12", mem[12], 16'h5555);
    check("op8_cycles", cyc, 10);
    check("op8_pc", pc_dbg, 5'd3);
`endif

    // MUL wraps to zero, JZ 7 taken
    clear_img();
    img[0] = ins(4'd0, 10); img[1] = ins(4'd4, 11); img[2] = ins(4'd6, 7);
    img[7] = ins(4'd1, 12);
    img[10] = 16'h0020; img[11] = 16'h0010; img[12] = 16'h5555;
    reset_and_load(1'b1);
    step(10);
    check("jz_fetch_addr", {bus.address, 3'(state_dbg)}, {5'd7, 3'(S_FETCH)});
    run_to_halt(100, cyc);
    check("jz_tail_cycles", cyc, 5);
    check("jz_mem12", mem[12], 16'd0);

    // PC wraps 31 -> 0
    clear_img();
    img[0] = ins(4'd6, 30); img[1] = ins(4'd1, 12);
    img[30] = ins(4'd0, 10); img[31] = ins(4'd2, 11);
    img[10] = 16'd5; img[11] = 16'd7; img[12] = 16'h5555;
    reset_and_load(1'b1);
    step(10);
    check("wrap_fetch_addr", {bus.address, 3'(state_dbg)}, {5'd0, 3'(S_FETCH)});
    run_to_halt(100, cyc);
    check("wrap_tail_cycles", cyc, 7);
    check("wrap_mem12", mem[12], 16'd12);

    // JMP to own address loops forever
    clear_img();
    img[0] = ins(4'd5, 0);
    reset_and_load(1'b1);
    step(30);
    check("selfloop", {bus.halted, bus.address, 3'(state_dbg)}, {1'b0, 5'd0, 3'(S_FETCH)});

    // run=0 holds the first fetch; raising run starts the program
    prog_basic();
    reset_and_load(1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("run_hold", {bus.readwriteN, bus.address, 3'(state_dbg)}, {1'b0, 5'd0, 3'(S_FETCH)});
    end
    bus.run = 1'b1;
    run_to_halt(100, cyc);
    check("run_start_cycles", cyc, 13);
    check("run_start_mem12", mem[12], 16'd12);

    // reset asserted during the STORE write cycle
    prog_basic();
    reset_and_load(1'b1);
    wait_n = 0;
    while (!bus.readwriteN && wait_n < 40) begin
      step(1);
      wait_n++;
    end
    check("write_reached_at", wait_n, 10);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {bus.readwriteN, bus.halted, 11'd0, bus.address, bus.data_out}, 32'd0);
    check("abort_regs", {3'(state_dbg), pc_dbg, acc_dbg}, {3'(S_FETCH), 5'd0, 8'd0});
    @(posedge clk);
    @(negedge clk);
    check("abort_no_write", mem[12], 16'h5555);
    rst_n = 1'b1;
    #1;
    check("abort_restart_addr", {bus.address, 3'(state_dbg)}, {5'd0, 3'(S_FETCH)});
    run_to_halt(100, cyc);
    check("abort_rerun_mem12", mem[12], 16'd12);

    // random forward-only programs against the reference model
    for (int it = 0; it < 40; it++) begin
      int r, opc, opd;
      for (int a = 16; a < 32; a++) begin
        img[a] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) img[a][7:0] = 8'h00;
      end
      for (int a = 0; a < 15; a++) begin
        r = $urandom_range(0, 12);
        opc = (r < 12) ? opc_tbl[r] : $urandom_range(9, 15);
        opd = (opc == 5 || opc == 6 || opc == 8) ? $urandom_range(a + 1, 15) : $urandom_range(16, 31);
        img[a] = {4'(opc), 7'($urandom), 5'(opd)};
      end
      img[15] = ins(4'd7, 0);
      exp_q.delete();
      model_run(exp_cyc, exp_acc, exp_pc);
      sb_en = 1'b1;
      reset_and_load(1'b1);
      run_to_halt(300, cyc);
      sb_en = 1'b0;
      check($sformatf("rand%0d_cycles", it), cyc, exp_cyc);
      check($sformatf("rand%0d_acc_pc", it), {acc_dbg, pc_dbg}, {exp_acc, exp_pc});
      check($sformatf("rand%0d_store_left", it), exp_q.size(), 0);
      bad = 0;
      for (int a = 16; a < 32; a++) if (mem[a] !== model_mem[a]) bad++;
      check($sformatf("rand%0d_mem", it), bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
